// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous RAM (1-cycle registered read) between the
// instruction-fetch port and the data port. Data has priority; a run counter
// bounds consecutive data wins while a fetch is pending, after which the fetch
// is granted once. Read data is steered back to whichever port owned the
// access in the previous cycle and held between valid pulses.
module mem_port_arbiter #(
    parameter int AW           = 16,
    parameter int DW           = 16,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Enable,
    // instruction-fetch port
    input  logic [AW-1:0] InstrAddr,
    input  logic          InstrRead,
    output logic          InstrWaitreq,
    output logic [DW-1:0] InstrIn,
    output logic          InstrValid,
    // data port
    input  logic [AW-1:0] DataAddr,
    input  logic          ReadData,
    input  logic          WriteData,
    input  logic [DW-1:0] DataOut,
    output logic          DataWaitreq,
    output logic [DW-1:0] DataIn,
    output logic          DataValid,
    // RAM side
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWrData,
    output logic          MemWren,
    input  logic [DW-1:0] MemRdData
);

    typedef enum logic {
        PRIO_D = 1'b0,
        PRIO_I = 1'b1
    } prio_t;

    localparam int CW = $clog2(MAX_DATA_RUN + 1);
    localparam logic [CW-1:0] RUN_LIMIT = CW'(MAX_DATA_RUN);
    localparam logic [CW-1:0] RUN_LAST  = CW'(MAX_DATA_RUN - 1);

    prio_t         prio;
    logic [CW-1:0] runCnt;

    logic          reqD;
    logic          gI;
    logic          gD;

    // owner of the read issued last cycle: [1] fetch, [0] data
    logic [1:0]    owner;
    logic [DW-1:0] instrHold;
    logic [DW-1:0] dataHold;

    assign reqD = ReadData | WriteData;

    // Grant decision: at most one port per cycle, priority state breaks ties
    always_comb begin
        gI = 1'b0;
        gD = 1'b0;
        if (!Reset && Enable) begin
            if (InstrRead && reqD) begin
                if (prio == PRIO_I) begin
                    gI = 1'b1;
                end else begin
                    gD = 1'b1;
                end
            end else begin
                gI = InstrRead;
                gD = reqD;
            end
        end
    end

    // Back-pressure: a requester waits whenever it was not granted
    always_comb begin
        InstrWaitreq = InstrRead & ~gI;
        DataWaitreq  = reqD & ~gD;
    end

    // RAM request mux; idle cycles park the address on the fetch port
    always_comb begin
        MemWrData = DataOut;
        MemAddr   = InstrAddr;
        MemWren   = 1'b0;
        if (gD) begin
            MemAddr = DataAddr;
            MemWren = WriteData;
        end else if (gI) begin
            MemAddr = InstrAddr;
        end
    end

    // Starvation guard: count data wins over a waiting fetch, flip priority at the limit
    always_ff @(posedge Clock) begin
        if (Reset) begin
            prio   <= PRIO_D;
            runCnt <= '0;
        end else if (gI) begin
            prio   <= PRIO_D;
            runCnt <= '0;
        end else if (!InstrRead) begin
            runCnt <= '0;
        end else if (prio == PRIO_D) begin
            if (runCnt >= RUN_LAST) begin
                runCnt <= RUN_LIMIT;
                prio   <= PRIO_I;
            end else begin
                runCnt <= runCnt + CW'(1);
            end
        end
    end

    // Track which port owns the data returning next cycle; a read+write is a write only
    always_ff @(posedge Clock) begin
        if (Reset) begin
            owner <= '0;
        end else begin
            owner <= {gI & InstrRead, gD & ReadData & ~WriteData};
        end
    end

    // Hold registers keep the last delivered word on each port between pulses
    always_ff @(posedge Clock) begin
        if (Reset) begin
            instrHold <= '0;
            dataHold  <= '0;
        end else begin
            if (InstrValid) begin
                instrHold <= MemRdData;
            end
            if (DataValid) begin
                dataHold <= MemRdData;
            end
        end
    end

    // Return path; Reset suppresses a pulse for a read granted just before it
    always_comb begin
        InstrValid = owner[1] & ~Reset;
        DataValid  = owner[0] & ~Reset;
        InstrIn    = InstrValid ? MemRdData : instrHold;
        DataIn     = DataValid  ? MemRdData : dataHold;
    end

endmodule
